logic_axi4_stream_packet_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that shares one AXI4-Stream datapath, typically the AXI4-Stream to Avalon-ST bridge, between `REQUESTERS` AXI4-Stream sources. Once a source is granted, it keeps the output until its `tlast` beat is accepted, so packets are never interleaved. The output is registered and carries `tid` forward as the Avalon-ST channel. A one-cycle arbitration state separates consecutive packets.

---
 rtl/logic_axi4_stream_packet_arbiter_if.sv | 29 ++
 rtl/logic_axi4_stream_packet_arbiter.sv | 135 +++++++++++++
 tb/tb_logic_axi4_stream_packet_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_axi4_stream_packet_arbiter_if.sv
// AXI4-Stream bundle of LANES parallel lanes. The arbiter uses one
// instance with LANES=REQUESTERS for its sources and one with LANES=1
// for its output.
interface logic_axi4_stream_packet_arbiter_if #(
    parameter int LANES       = 1,
    parameter int TDATA_BYTES = 4,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1
);
    logic [LANES-1:0]                        tvalid;
    logic [LANES-1:0]                        tready;
    logic [LANES-1:0]                        tlast;
    logic [LANES-1:0][TDATA_BYTES-1:0][7:0]  tdata;
    logic [LANES-1:0][TDATA_BYTES-1:0]       tkeep;
    logic [LANES-1:0][TUSER_WIDTH-1:0]       tuser;
    logic [LANES-1:0][TID_WIDTH-1:0]         tid;

    // Side that produces beats.
    modport master (
        output tvalid, tlast, tdata, tkeep, tuser, tid,
        input  tready
    );

    // Side that consumes beats.
    modport slave (
        input  tvalid, tlast, tdata, tkeep, tuser, tid,
        output tready
    );
endinterface

// File: rtl/logic_axi4_stream_packet_arbiter.sv
// Packet-atomic round-robin arbiter: shares one registered AXI4-Stream
// output between REQUESTERS sources. A granted source keeps the output
// until its tlast beat is accepted; one IDLE arbitration cycle separates
// consecutive packets. tid is forwarded unchanged as the channel number.
module logic_axi4_stream_packet_arbiter #(
    parameter int REQUESTERS  = 2,
    parameter int TDATA_BYTES = 4,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int GRANT_WIDTH = $clog2(REQUESTERS)
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    logic_axi4_stream_packet_arbiter_if.slave      rx,
    logic_axi4_stream_packet_arbiter_if.master     tx,
    output logic [GRANT_WIDTH-1:0]                 grant,
    output logic                                   busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Requester count at the width of the wrap-around sum below.
    localparam logic [GRANT_WIDTH:0] REQ_W = (GRANT_WIDTH + 1)'(REQUESTERS);
    // Grant value after reset: the last index, so source 0 wins first.
    localparam logic [GRANT_WIDTH-1:0] GRANT_RST = GRANT_WIDTH'(REQUESTERS - 1);

    state_t                          state;
    logic [GRANT_WIDTH-1:0]          next_grant;
    logic                            any_valid;
    logic [REQUESTERS-1:0]           ready;
    logic                            accept;

    // Output register (one beat deep).
    logic                            out_valid;
    logic                            out_last;
    logic [TDATA_BYTES-1:0][7:0]     out_data;
    logic [TDATA_BYTES-1:0]          out_keep;
    logic [TUSER_WIDTH-1:0]          out_user;
    logic [TID_WIDTH-1:0]            out_id;

    // Round-robin search: first valid source starting just above the
    // current grant, wrapping, so the last winner has lowest priority.
    always_comb begin
        logic [GRANT_WIDTH:0]   sum;
        logic [GRANT_WIDTH-1:0] idx;
        // NOTE: every variable gets a default before any condition;
        // a path that leaves one unassigned would infer a latch.
        next_grant = grant;
        any_valid  = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int i = 1; i <= REQUESTERS; i++) begin
            sum = {1'b0, grant} + (GRANT_WIDTH + 1)'(i);
            if (sum >= REQ_W) begin
                sum = sum - REQ_W;
            end
            idx = sum[GRANT_WIDTH-1:0];
            if (!any_valid && rx.tvalid[idx]) begin
                any_valid  = 1'b1;
                next_grant = idx;
            end
        end
    end

    // Only the granted source sees ready, and only while the output
    // register is empty or draining this cycle.
    always_comb begin
        ready = '0;
        if (state == ST_BUSY) begin
            ready[grant] = !out_valid || tx.tready[0];
        end
    end

    assign rx.tready = ready;
    assign accept    = (state == ST_BUSY) && rx.tvalid[grant] && ready[grant];
    assign busy      = (state == ST_BUSY);

    // FSM, grant pointer and output register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            // NOTE: the payload registers are reset as well, because the
            // tx payload must read zero after reset; a pure datapath
            // register could otherwise be left without reset.
            state     <= ST_IDLE;
            grant     <= GRANT_RST;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_user  <= '0;
            out_id    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here
            // samples pre-edge values and updates together.
            if (accept) begin
                out_valid <= 1'b1;
                out_last  <= rx.tlast[grant];
                out_data  <= rx.tdata[grant];
                out_keep  <= rx.tkeep[grant];
                out_user  <= rx.tuser[grant];
                out_id    <= rx.tid[grant];
            end else if (tx.tready[0]) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant <= next_grant;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Ownership ends with the accepted tlast beat; the
                    // output register still drains on its own.
                    if (accept && rx.tlast[grant]) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign tx.tvalid[0] = out_valid;
    assign tx.tlast[0]  = out_last;
    assign tx.tdata[0]  = out_data;
    assign tx.tkeep[0]  = out_keep;
    assign tx.tuser[0]  = out_user;
    assign tx.tid[0]    = out_id;

endmodule

// File: tb/tb_logic_axi4_stream_packet_arbiter.sv
// Directed bench for the packet arbiter with four sources. Inputs change
// 1 ns after the rising edge; outputs are sampled on the falling edge and
// logged per cycle, then compared with hand-computed cycles and values.
module tb_logic_axi4_stream_packet_arbiter;

    localparam int REQ   = 4;
    localparam int BYTES = 4;
    localparam int UW    = 1;
    localparam int IW    = 1;
    localparam int GW    = 2;
    localparam int HMAX  = 512;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        user;
        logic        id;
        logic        last;
    } beat_t;

    typedef struct {
        beat_t b;
        int    cyc;
    } rec_t;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [GW-1:0] grant;
    logic          busy;

    always #5 aclk = ~aclk;

    logic_axi4_stream_packet_arbiter_if #(.LANES(REQ), .TDATA_BYTES(BYTES),
        .TUSER_WIDTH(UW), .TID_WIDTH(IW)) rx_bus ();
    logic_axi4_stream_packet_arbiter_if #(.LANES(1), .TDATA_BYTES(BYTES),
        .TUSER_WIDTH(UW), .TID_WIDTH(IW)) tx_bus ();

    logic_axi4_stream_packet_arbiter #(
        .REQUESTERS(REQ), .TDATA_BYTES(BYTES), .TUSER_WIDTH(UW),
        .TID_WIDTH(IW), .GRANT_WIDTH(GW)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .rx     (rx_bus),
        .tx     (tx_bus),
        .grant  (grant),
        .busy   (busy)
    );

    beat_t         src_q [REQ][$];
    rec_t          out_q [$];
    int            glog_g [$];
    int            glog_c [$];
    logic          h_busy   [0:HMAX-1];
    logic [GW-1:0] h_grant  [0:HMAX-1];
    logic          h_tvalid [0:HMAX-1];
    logic [31:0]   h_tdata  [0:HMAX-1];
    logic [REQ-1:0] h_rready [0:HMAX-1];

    int       cyc = 0;
    int       total = 0;
    int       bad = 0;
    int       stall_lo = 1000;
    int       stall_hi = 0;
    logic     prev_busy = 1'b0;
    logic [REQ-1:0] hs;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int l, input logic [31:0] d, input logic [3:0] k,
                        input logic u, input logic i, input logic last);
        beat_t b;
        b.data = d; b.keep = k; b.user = u; b.id = i; b.last = last;
        src_q[l].push_back(b);
    endtask

    // Present the head of each source queue and the tx_tready pattern.
    task automatic drive();
        for (int l = 0; l < REQ; l++) begin
            if (src_q[l].size() > 0) begin
                rx_bus.tvalid[l] = 1'b1;
                rx_bus.tlast[l]  = src_q[l][0].last;
                rx_bus.tdata[l]  = src_q[l][0].data;
                rx_bus.tkeep[l]  = src_q[l][0].keep;
                rx_bus.tuser[l]  = src_q[l][0].user;
                rx_bus.tid[l]    = src_q[l][0].id;
            end else begin
                rx_bus.tvalid[l] = 1'b0;
                rx_bus.tlast[l]  = 1'b0;
                rx_bus.tdata[l]  = '0;
                rx_bus.tkeep[l]  = '0;
                rx_bus.tuser[l]  = '0;
                rx_bus.tid[l]    = '0;
            end
        end
        tx_bus.tready[0] = !((cyc + 1 >= stall_lo) && (cyc + 1 <= stall_hi));
    endtask

    // One clock: sample and log at the falling edge, then advance sources
    // that handshook at the rising edge.
    task automatic cycle();
        rec_t r;
        @(negedge aclk);
        if (cyc < HMAX - 1) cyc++;
        h_busy[cyc]   = busy;
        h_grant[cyc]  = grant;
        h_tvalid[cyc] = tx_bus.tvalid[0];
        h_tdata[cyc]  = tx_bus.tdata[0];
        h_rready[cyc] = rx_bus.tready;
        if (busy && !prev_busy) begin
            glog_g.push_back(int'(grant));
            glog_c.push_back(cyc);
        end
        prev_busy = busy;
        if (tx_bus.tvalid[0] && tx_bus.tready[0]) begin
            r.b.data = tx_bus.tdata[0];
            r.b.keep = tx_bus.tkeep[0];
            r.b.user = tx_bus.tuser[0];
            r.b.id   = tx_bus.tid[0];
            r.b.last = tx_bus.tlast[0];
            r.cyc    = cyc;
            out_q.push_back(r);
        end
        hs = rx_bus.tvalid & rx_bus.tready;
        @(posedge aclk);
        #1;
        for (int l = 0; l < REQ; l++) begin
            if (hs[l] && src_q[l].size() > 0) void'(src_q[l].pop_front());
        end
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic check_out(input string tag, input int j, input logic [31:0] d,
                             input int c, input logic last);
        if (j < out_q.size()) begin
            check({tag, "_data"}, out_q[j].b.data, d);
            check({tag, "_cyc"},  out_q[j].cyc, c);
            check({tag, "_last"}, out_q[j].b.last, last);
        end else begin
            check({tag, "_count"}, out_q.size(), j + 1);
        end
    endtask

    task automatic check_grant(input string tag, input int k, input int g, input int c);
        if (k < glog_g.size()) begin
            check({tag, "_grant"}, glog_g[k], g);
            check({tag, "_gcyc"},  glog_c[k], c);
        end else begin
            check({tag, "_gcount"}, glog_g.size(), k + 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s;
        int gb;

        // ---------------- reset values ----------------
        drive();
        run(2);
        check("rst_tvalid", tx_bus.tvalid[0], 0);
        check("rst_tlast",  tx_bus.tlast[0], 0);
        check("rst_busy",   busy, 0);
        check("rst_grant",  grant, 3);
        check("rst_tdata",  tx_bus.tdata[0], 0);
        check("rst_tkeep",  tx_bus.tkeep[0], 0);
        check("rst_tuser",  tx_bus.tuser[0], 0);
        check("rst_tid",    tx_bus.tid[0], 0);
        check("rst_rready", rx_bus.tready, 0);
        areset = 1'b0;

        // ---------------- single source 2, 3 beats ----------------
        out_q.delete();
        gb = glog_g.size();
        push(2, 32'hA0, 4'hF, 0, 0, 0);
        push(2, 32'hA1, 4'hF, 0, 0, 0);
        push(2, 32'hA2, 4'hF, 0, 0, 1);
        drive();
        s = cyc + 1;
        run(7);
        check_grant("t1", gb, 2, s + 1);
        check("t1_tvalid_early", h_tvalid[s + 1], 0);
        check("t1_count", out_q.size(), 3);
        for (int j = 0; j < 3; j++)
            check_out("t1", j, 32'hA0 + 32'(j), s + 2 + j, j == 2);
        check("t1_busy_mid", h_busy[s + 3], 1);
        check("t1_busy_end", h_busy[s + 4], 0);

        // ---------------- round robin, all four sources ----------------
        areset = 1'b1;
        drive();
        run(1);
        check("t2_rst_grant", grant, 3);
        areset = 1'b0;
        out_q.delete();
        gb = glog_g.size();
        for (int l = 0; l < REQ; l++)
            for (int p = 0; p < 2; p++)
                for (int b = 0; b < 2; b++)
                    push(l, 32'(l * 256 + p * 16 + b), 4'hF, 0, 0, b == 1);
        drive();
        s = cyc + 1;
        run(28);
        check("t2_count", out_q.size(), 16);
        for (int k = 0; k < 8; k++) begin
            check_grant("t2", gb + k, k % 4, s + 1 + 3 * k);
            for (int b = 0; b < 2; b++)
                check_out("t2", 2 * k + b, 32'((k % 4) * 256 + (k / 4) * 16 + b),
                          s + 2 + 3 * k + b, b == 1);
        end

        // ---------------- backpressure on source 1 ----------------
        out_q.delete();
        gb = glog_g.size();
        push(1, 32'hB0, 4'hF, 0, 0, 0);
        push(1, 32'hB1, 4'hF, 0, 0, 0);
        push(1, 32'hB2, 4'hF, 0, 0, 0);
        push(1, 32'hB3, 4'hF, 0, 0, 1);
        s = cyc + 1;
        stall_lo = s + 3;
        stall_hi = s + 7;
        drive();
        run(13);
        stall_lo = 1000;
        stall_hi = 0;
        check_grant("t3", gb, 1, s + 1);
        for (int c = s + 3; c <= s + 7; c++) begin
            check("t3_stall_tdata",  h_tdata[c], 32'hB1);
            check("t3_stall_tvalid", h_tvalid[c], 1);
            check("t3_stall_rready", h_rready[c], 0);
        end
        check("t3_count", out_q.size(), 4);
        check_out("t3_b0", 0, 32'hB0, s + 2, 0);
        check_out("t3_b1", 1, 32'hB1, s + 8, 0);
        check_out("t3_b2", 2, 32'hB2, s + 9, 0);
        check_out("t3_b3", 3, 32'hB3, s + 10, 1);

        // ---------------- packet atomicity ----------------
        out_q.delete();
        gb = glog_g.size();
        push(1, 32'hC0, 4'hF, 0, 0, 0);
        push(1, 32'hC1, 4'hF, 0, 0, 0);
        push(1, 32'hC2, 4'hF, 0, 0, 1);
        drive();
        s = cyc + 1;
        run(2);
        push(0, 32'hD0, 4'hF, 0, 0, 0);
        push(0, 32'hD1, 4'hF, 0, 0, 1);
        drive();
        run(10);
        for (int c = s + 2; c <= s + 4; c++)
            check("t4_rready0_held", h_rready[c][0], 0);
        check("t4_rready0_open", h_rready[s + 5][0], 1);
        check_grant("t4_first", gb, 1, s + 1);
        check_grant("t4_next", gb + 1, 0, s + 5);
        check("t4_count", out_q.size(), 5);
        check_out("t4_c0", 0, 32'hC0, s + 2, 0);
        check_out("t4_c2", 2, 32'hC2, s + 4, 1);
        check_out("t4_d0", 3, 32'hD0, s + 6, 0);
        check_out("t4_d1", 4, 32'hD1, s + 7, 1);

        // ---------------- sideband pass-through ----------------
        out_q.delete();
        gb = glog_g.size();
        push(3, 32'hE0, 4'hF, 0, 0, 0);
        push(3, 32'hE1, 4'b0011, 1, 1, 1);
        drive();
        s = cyc + 1;
        run(7);
        check_grant("t5", gb, 3, s + 1);
        check("t5_count", out_q.size(), 2);
        if (out_q.size() == 2) begin
            check("t5_first_keep", out_q[0].b.keep, 4'hF);
            check("t5_first_id",   out_q[0].b.id, 0);
            check("t5_last_data",  out_q[1].b.data, 32'hE1);
            check("t5_last_keep",  out_q[1].b.keep, 4'b0011);
            check("t5_last_user",  out_q[1].b.user, 1);
            check("t5_last_id",    out_q[1].b.id, 1);
            check("t5_last_last",  out_q[1].b.last, 1);
        end

        // ---------------- reset mid-packet ----------------
        out_q.delete();
        gb = glog_g.size();
        push(1, 32'hF0, 4'hF, 0, 0, 0);
        push(1, 32'hF1, 4'hF, 0, 0, 0);
        push(1, 32'hF2, 4'hF, 0, 0, 0);
        push(1, 32'hF3, 4'hF, 0, 0, 1);
        drive();
        s = cyc + 1;
        run(3);
        areset = 1'b1;
        drive();
        run(1);
        for (int l = 0; l < REQ; l++) src_q[l].delete();
        areset = 1'b0;
        push(0, 32'h50, 4'hF, 0, 0, 1);
        push(1, 32'h51, 4'hF, 0, 0, 1);
        drive();
        run(7);
        check("t6_tvalid_after_rst", h_tvalid[s + 4], 0);
        check("t6_busy_after_rst",   h_busy[s + 4], 0);
        check("t6_grant_after_rst",  h_grant[s + 4], 3);
        check("t6_count", out_q.size(), 4);
        check_out("t6_f0", 0, 32'hF0, s + 2, 0);
        check_out("t6_f1", 1, 32'hF1, s + 3, 0);
        check_out("t6_src0", 2, 32'h50, s + 6, 1);
        check_out("t6_src1", 3, 32'h51, s + 8, 1);
        check_grant("t6_abort", gb, 1, s + 1);
        check_grant("t6_src0", gb + 1, 0, s + 5);
        check_grant("t6_src1", gb + 2, 1, s + 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
